quad_decoder: RTL

- Upstream front end of the pulse-counter IP. Takes raw quadrature encoder channels A/B from the wheel encoder pins and conditions them: synchronisation, glitch filtering and quadrature decoding.
- Produces the single-cycle count strobe and the direction bit that drive the downstream counter's cnt and ud inputs.
- Flags illegal transitions, where both channels change at once, and keeps a saturating error tally for software.

---
 rtl/quad_decoder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: per-channel synchroniser and glitch filter,
// followed by an x1/x2/x4 decoder with illegal-transition detection.
module quad_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic                 a_in,
  input  logic                 b_in,
  input  logic                 err_clr,
  output logic                 cnt,
  output logic                 ud,
  output logic                 err,
  output logic [ERR_WIDTH-1:0] err_cnt,
  output logic [1:0]           ab_filt
);

  localparam int FC_W  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [FC_W-1:0]  FC_LAST     = FC_W'(FILTER_LEN - 1);
  localparam logic [SET_W-1:0] SETTLE_DONE = SET_W'(SYNC_STAGES);

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

  // Bit 1 carries channel A, bit 0 channel B throughout.
  logic [1:0] raw;
  logic [1:0] sync_s;
  logic [1:0] filt;
  logic [1:0] fc_zero;

  assign raw = {a_in, b_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [FC_W-1:0]        fc_reg;
      logic                   filt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg <= '0;
          fc_reg   <= '0;
          filt_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw[gi]};
          // A new level is accepted only after FILTER_LEN consecutive
          // cycles of disagreement with the current filtered level.
          if (sync_reg[SYNC_STAGES-1] == filt_reg) begin
            fc_reg <= '0;
          end else if (fc_reg == FC_LAST) begin
            filt_reg <= sync_reg[SYNC_STAGES-1];
            fc_reg   <= '0;
          end else begin
            fc_reg <= fc_reg + 1'b1;
          end
        end
      end

      assign sync_s[gi]  = sync_reg[SYNC_STAGES-1];
      assign filt[gi]    = filt_reg;
      assign fc_zero[gi] = (fc_reg == '0);
    end
  endgenerate

  assign ab_filt = filt;

  state_t               state_reg;
  logic [SET_W-1:0]     settle_reg;
  logic                 quiet_reg;
  logic [1:0]           prev_reg;
  logic                 cnt_reg;
  logic                 ud_reg;
  logic                 err_reg;
  logic [ERR_WIDTH-1:0] err_cnt_reg;

  logic [1:0] change;
  logic       dir_rev;
  logic       single_chg;
  logic       count_hit;
  logic       quiet;

  always_comb begin
    change     = prev_reg ^ filt;
    dir_rev    = prev_reg[1] ^ filt[0];
    single_chg = (change == 2'b01) || (change == 2'b10);
    quiet      = (fc_zero == 2'b11) && (sync_s == filt);
    count_hit  = 1'b0;
    case (mode)
      // x1: A rising while moving forward, A falling while moving reverse.
      2'd0:    count_hit = change[1] && (filt[1] ? !dir_rev : dir_rev);
      2'd1:    count_hit = change[1];
      default: count_hit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_INIT;
      settle_reg  <= '0;
      quiet_reg   <= 1'b0;
      prev_reg    <= 2'b00;
      cnt_reg     <= 1'b0;
      ud_reg      <= 1'b0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      cnt_reg <= 1'b0;
      err_reg <= 1'b0;
      case (state_reg)
        ST_INIT: begin
          // Let the synchronisers fill with real pin levels before judging
          // the filters quiet, so reset-time zeros never look like motion.
          if (settle_reg != SETTLE_DONE) begin
            settle_reg <= settle_reg + 1'b1;
          end else begin
            quiet_reg <= quiet;
            if (quiet_reg && quiet) begin
              prev_reg  <= filt;
              state_reg <= ST_RUN;
            end
          end
        end
        default: begin
          prev_reg <= filt;
          if (en) begin
            if (change == 2'b11) begin
              err_reg <= 1'b1;
              if (err_cnt_reg != '1) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
              end
            end else if (single_chg && count_hit) begin
              cnt_reg <= 1'b1;
              ud_reg  <= dir_rev;
            end
          end
        end
      endcase
      if (err_clr) begin
        err_cnt_reg <= '0;
      end
    end
  end

  assign cnt     = cnt_reg;
  assign ud      = ud_reg;
  assign err     = err_reg;
  assign err_cnt = err_cnt_reg;

endmodule
